md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencing controller for the multi-cycle multiply/divide unit in the E stage.
- Accepts MD operations from E, runs the latency counter, and drives busy for the unit.
- Generates the start pulse, HI/LO commit strobe, mthi/mtlo write enables and the D-stage stall request.
- Sits between the E-stage decode and the MD arithmetic/HI-LO registers; the arithmetic itself is outside this block.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_LAT, 10, busy cycles for div/divu (legal range 1..15)
- CNT_W, 4, latency counter width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- valid_e  input  1  E-stage instruction valid (not a bubble)
- op_e  input  4  MD op code of the E-stage instruction (define.v encoding)
- md_use_d  input  1  D-stage instruction is any MD op (mult/div/mf/mt)
- start  output  1  combinational; pulse in the accept cycle, datapath latches operands
- op_q  output  4  registered op of the running operation; MD_NONE when idle
- busy  output  1  operation in flight
- commit  output  1  final busy cycle; HI/LO load shadow results at the end of this cycle
- hi_we  output  1  mthi write enable
- lo_we  output  1  mtlo write enable
- stall_d  output  1  freeze PC/D and bubble E
- ovr_err  output  1  sticky; MD op arrived in E while busy

Behaviour:
- Reset is asynchronous and active-high. While asserted: state=IDLE, cnt=0, op_q=MD_NONE, busy=0, commit=0, ovr_err=0. All combinational outputs evaluate to 0 in IDLE with valid_e=0.
- States:
  - IDLE -> RUN when accept is true.
  - RUN -> IDLE on the edge ending the commit cycle.
- accept = IDLE & valid_e & op_e ∈ {MULT, MULTU, DIV, DIVU}.
- start = accept.
- On the accept edge:
  - cnt <= MULT_LAT for mult/multu, or DIV_LAT for div/divu.
  - op_q <= op_e.
- In RUN:
  - busy=1.
  - cnt decrements every cycle.
  - commit = (cnt==1).
- Timeline for an accept in cycle T:
  - busy is high in cycles T+1 .. T+LAT.
  - commit is high in cycle T+LAT.
  - busy=0 in cycle T+LAT+1, where a new accept is already legal.
- hi_we = valid_e & op_e==MTHI & ~busy & ~start.
- lo_we = valid_e & op_e==MTLO & ~busy & ~start.
- stall_d = md_use_d & (start | busy). The stall holds through the commit cycle and releases in cycle T+LAT+1.
- MD op in E while busy: this must not occur given stall_d. If it does occur:
  - The op is ignored: no restart, no hi_we/lo_we.
  - ovr_err is set and stays set until reset.
- Non-MD op_e, or valid_e=0: no effect in any state.
- Reset mid-operation: returns to IDLE immediately; commit is never issued, so HI/LO keep their values.
- Counter never wraps. Loading a LAT outside 1..15 is a configuration error; an elaboration-time check is required.

Decomposition:
- define.v holds the MD op encoding:
  - MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4
  - MFHI=5, MFLO=6, MTHI=7, MTLO=8
- define.v also holds the state encoding: IDLE=0, RUN=1.
- One sub-module, md_cnt: a loadable down-counter with load/value inputs and an is_one output.
- Everything else stays in md_sched.

Test Plan:
- mult accepted at cycle 0 -> start=1 at cycle 0; busy=1 in cycles 1–5; commit=1 only at cycle 5; busy=0 at cycle 6.
- divu at cycle 0 with md_use_d=1 held -> stall_d=1 in cycles 0–10 and 0 at cycle 11; commit only at cycle 10.
- mthi with valid_e=1 while idle -> hi_we=1 in that cycle only. Same mthi at cycle 2 of a running mult -> hi_we=0 and ovr_err=1 from cycle 3, sticky.
- Back-to-back: mult at cycle 0 and multu presented at cycle 6 -> second start=1 at cycle 6; busy continuous 1–5 then 7–11, with cycle 6 busy=0.
- Reset asserted asynchronously mid-edge in cycle 4 of a div -> busy=0 and op_q=0 immediately; no commit pulse; next div accepted normally after release.
- valid_e=0 with op_e=DIV, or op_e=MFHI with valid_e=1 -> start=0, busy remains 0.

Source files
------------

// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared op/state encodings and decode helpers for the MD sequencer
//
// Contents:
//   MD_* op codes  4-bit MD op encoding carried on op_e / op_q
//   state_e        sequencer state encoding (ST_IDLE=0, ST_RUN=1)
//   md_is_arith    op starts a multi-cycle mult/div operation
//   md_is_div      op uses the divide latency
//   md_is_any      op is any MD instruction (arith, mf*, mt*)

package md_sched_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic md_is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_any(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/md_cnt.sv
// rtl/md_cnt.sv - loadable saturating down-counter for the MD latency
//
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset, clears the count
//   load    load value into the counter (takes priority over dec)
//   value   count to load
//   dec     decrement by one; holds at zero so the count never wraps
//   cnt     current count
//   is_one  count equals one (final busy cycle)

module md_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_one
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - E-stage sequencing controller for the multi-cycle multiply/divide unit
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   valid_e   E-stage instruction valid
//   op_e      MD op of the E-stage instruction
//   md_use_d  D-stage instruction is any MD op
//   start     accept pulse; datapath latches operands this cycle
//   op_q      op of the running operation, MD_NONE when idle
//   busy      operation in flight
//   commit    final busy cycle; HI/LO load results at its end
//   hi_we     mthi write enable
//   lo_we     mtlo write enable
//   stall_d   freeze PC/D and bubble E
//   ovr_err   sticky: MD op reached E while busy

module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_e,
    input  logic [3:0] op_e,
    input  logic       md_use_d,
    output logic       start,
    output logic [3:0] op_q,
    output logic       busy,
    output logic       commit,
    output logic       hi_we,
    output logic       lo_we,
    output logic       stall_d,
    output logic       ovr_err
);

    // A latency of zero or one that does not fit the counter would make the
    // commit cycle unreachable, so refuse to elaborate.
    if (MULT_LAT < 1 || MULT_LAT > 15 || MULT_LAT >= (1 << CNT_W)) begin : g_bad_mult_lat
        $error("md_sched: MULT_LAT out of range");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15 || DIV_LAT >= (1 << CNT_W)) begin : g_bad_div_lat
        $error("md_sched: DIV_LAT out of range");
    end

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    state_e           state;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_value;
    logic             cnt_is_one;
    logic             md_in_e;

    assign md_in_e    = valid_e && md_is_any(op_e);
    assign accept     = (state == ST_IDLE) && valid_e && md_is_arith(op_e);
    assign load_value = md_is_div(op_e) ? DIV_CNT : MULT_CNT;

    md_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .value  (load_value),
        .dec    (state == ST_RUN),
        .cnt    (cnt),
        .is_one (cnt_is_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= MD_NONE;
            ovr_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        op_q  <= op_e;
                    end
                end
                ST_RUN: begin
                    // Any MD op in E here slipped past stall_d; it is dropped.
                    if (md_in_e) begin
                        ovr_err <= 1'b1;
                    end
                    if (cnt_is_one) begin
                        state <= ST_IDLE;
                        op_q  <= MD_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    op_q  <= MD_NONE;
                end
            endcase
        end
    end

    assign start   = accept;
    assign busy    = (state == ST_RUN);
    assign commit  = busy && cnt_is_one;
    assign hi_we   = valid_e && (op_e == MD_MTHI) && !busy && !start;
    assign lo_we   = valid_e && (op_e == MD_MTLO) && !busy && !start;
    assign stall_d = md_use_d && (start || busy);

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched

module tb_md_sched;
    import md_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_e;
    logic [3:0] op_e;
    logic       md_use_d;
    logic       start;
    logic [3:0] op_q;
    logic       busy;
    logic       commit;
    logic       hi_we;
    logic       lo_we;
    logic       stall_d;
    logic       ovr_err;

    int checks = 0;
    int errors = 0;

    md_sched #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_e  (valid_e),
        .op_e     (op_e),
        .md_use_d (md_use_d),
        .start    (start),
        .op_q     (op_q),
        .busy     (busy),
        .commit   (commit),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .stall_d  (stall_d),
        .ovr_err  (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_e = 1'b0;
        op_e = MD_NONE;
        md_use_d = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_e = 1'b0;
        op_e = MD_NONE;
        md_use_d = 1'b0;
        #2;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({busy, commit, ovr_err, start, hi_we, lo_we, stall_d} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000000", {busy, commit, ovr_err, start, hi_we, lo_we, stall_d});
        end
        checks++;
        if (op_q !== MD_NONE) begin
            errors++;
            $display("FAIL reset_op_q got %0d exp 0", op_q);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_mult();
        valid_e = 1'b1;
        op_e = MD_MULT;
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_start got start=%b busy=%b exp start=1 busy=0", start, busy);
        end
        next_cycle();
        valid_e = 1'b0;
        op_e = MD_NONE;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== (c <= 5) || commit !== (c == 5) || op_q !== ((c <= 5) ? MD_MULT : MD_NONE)) begin
                errors++;
                $display("FAIL mult_cycle c=%0d got busy=%b commit=%b op_q=%0d exp busy=%b commit=%b op_q=%0d",
                         c, busy, commit, op_q, c <= 5, c == 5, (c <= 5) ? MD_MULT : MD_NONE);
            end
            next_cycle();
        end
    endtask

    task automatic test_divu_stall();
        md_use_d = 1'b1;
        valid_e = 1'b1;
        op_e = MD_DIVU;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            checks++;
            if (stall_d !== (c <= 10) || commit !== (c == 10)) begin
                errors++;
                $display("FAIL divu_stall c=%0d got stall_d=%b commit=%b exp stall_d=%b commit=%b",
                         c, stall_d, commit, c <= 10, c == 10);
            end
            next_cycle();
            valid_e = 1'b0;
            op_e = MD_NONE;
        end
        md_use_d = 1'b0;
    endtask

    task automatic test_mt();
        valid_e = 1'b1;
        op_e = MD_MTHI;
        @(negedge clk);
        checks++;
        if (hi_we !== 1'b1 || lo_we !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL mthi_idle got hi_we=%b lo_we=%b start=%b exp 1 0 0", hi_we, lo_we, start);
        end
        next_cycle();
        op_e = MD_MTLO;
        @(negedge clk);
        checks++;
        if (lo_we !== 1'b1 || hi_we !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_idle got lo_we=%b hi_we=%b exp 1 0", lo_we, hi_we);
        end
        next_cycle();
        valid_e = 1'b0;
        op_e = MD_NONE;
        @(negedge clk);
        checks++;
        if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
            errors++;
            $display("FAIL mt_one_cycle got hi_we=%b lo_we=%b exp 0 0", hi_we, lo_we);
        end
        next_cycle();

        // mult at cycle 0, mthi slips into E at cycle 2
        valid_e = 1'b1;
        op_e = MD_MULT;
        for (int c = 0; c <= 7; c++) begin
            if (c == 2) begin
                valid_e = 1'b1;
                op_e = MD_MTHI;
            end
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (hi_we !== 1'b0 || start !== 1'b0 || ovr_err !== 1'b0) begin
                    errors++;
                    $display("FAIL mthi_busy got hi_we=%b start=%b ovr_err=%b exp 0 0 0", hi_we, start, ovr_err);
                end
            end
            if (c >= 3) begin
                checks++;
                if (ovr_err !== 1'b1 || busy !== (c <= 5)) begin
                    errors++;
                    $display("FAIL ovr_sticky c=%0d got ovr_err=%b busy=%b exp 1 %b", c, ovr_err, busy, c <= 5);
                end
            end
            next_cycle();
            valid_e = 1'b0;
            op_e = MD_NONE;
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (ovr_err !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b exp 0", ovr_err);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        valid_e = 1'b1;
        op_e = MD_MULT;
        for (int c = 0; c <= 12; c++) begin
            if (c == 6) begin
                valid_e = 1'b1;
                op_e = MD_MULTU;
            end
            @(negedge clk);
            exp_busy = ((c >= 1) && (c <= 5)) || ((c >= 7) && (c <= 11));
            checks++;
            if (busy !== exp_busy || start !== ((c == 0) || (c == 6))) begin
                errors++;
                $display("FAIL b2b c=%0d got busy=%b start=%b exp busy=%b start=%b",
                         c, busy, start, exp_busy, (c == 0) || (c == 6));
            end
            if (c == 8) begin
                checks++;
                if (op_q !== MD_MULTU) begin
                    errors++;
                    $display("FAIL b2b_op_q got %0d exp %0d", op_q, MD_MULTU);
                end
            end
            next_cycle();
            valid_e = 1'b0;
            op_e = MD_NONE;
        end
    endtask

    task automatic test_reset_mid();
        int commits;
        valid_e = 1'b1;
        op_e = MD_DIV;
        next_cycle();
        valid_e = 1'b0;
        op_e = MD_NONE;
        next_cycle();
        next_cycle();
        next_cycle();
        // now in cycle 4 of the div
        checks++;
        if (busy !== 1'b1 || op_q !== MD_DIV) begin
            errors++;
            $display("FAIL div_running got busy=%b op_q=%0d exp 1 %0d", busy, op_q, MD_DIV);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || op_q !== MD_NONE || commit !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b op_q=%0d commit=%b exp 0 0 0", busy, op_q, commit);
        end
        next_cycle();
        reset = 1'b0;
        commits = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (commit === 1'b1 || busy === 1'b1) commits++;
            next_cycle();
        end
        checks++;
        if (commits != 0) begin
            errors++;
            $display("FAIL no_commit_after_reset got %0d busy/commit cycles exp 0", commits);
        end
        valid_e = 1'b1;
        op_e = MD_DIV;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            checks++;
            if (start !== (c == 0) || busy !== ((c >= 1) && (c <= 10)) || commit !== (c == 10)) begin
                errors++;
                $display("FAIL div_after_reset c=%0d got start=%b busy=%b commit=%b exp %b %b %b",
                         c, start, busy, commit, c == 0, (c >= 1) && (c <= 10), c == 10);
            end
            next_cycle();
            valid_e = 1'b0;
            op_e = MD_NONE;
        end
    endtask

    task automatic test_no_effect();
        valid_e = 1'b0;
        op_e = MD_DIV;
        @(negedge clk);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL invalid_div_start got %b exp 0", start);
        end
        next_cycle();
        valid_e = 1'b1;
        op_e = MD_MFHI;
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) begin
            errors++;
            $display("FAIL mfhi_no_start got start=%b busy=%b hi_we=%b lo_we=%b exp 0 0 0 0", start, busy, hi_we, lo_we);
        end
        next_cycle();
        valid_e = 1'b0;
        op_e = MD_NONE;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ovr_err !== 1'b0) begin
            errors++;
            $display("FAIL no_effect_idle got busy=%b ovr_err=%b exp 0 0", busy, ovr_err);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_stall();
        test_mt();
        test_back_to_back();
        test_reset_mid();
        test_no_effect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
